// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The slave side is the hazard controller; the master side is whatever
// drives the pipeline status (the datapath, or a bench).
interface hazard_ctrl_if;
  logic [4:0]  IFID_rs__i;
  logic [4:0]  IFID_rt__i;
  logic        IFID_uses_hilo__i;
  logic        IDEX_mem_read__i;
  logic [4:0]  IDEX_rt__i;
  logic        branch_taken__i;
  logic        jump__i;
  logic        muldiv_start__i;
  logic        mem_wait__i;

  logic        pc_enable__o;
  logic        ifid_enable__o;
  logic        ifid_flush__o;
  logic        idex_bubble__o;
  logic        freeze__o;
  logic        muldiv_busy__o;
  logic [15:0] stall_cycles__o;

  modport slave (
    input  IFID_rs__i, IFID_rt__i, IFID_uses_hilo__i, IDEX_mem_read__i,
           IDEX_rt__i, branch_taken__i, jump__i, muldiv_start__i, mem_wait__i,
    output pc_enable__o, ifid_enable__o, ifid_flush__o, idex_bubble__o,
           freeze__o, muldiv_busy__o, stall_cycles__o
  );

  modport master (
    output IFID_rs__i, IFID_rt__i, IFID_uses_hilo__i, IDEX_mem_read__i,
           IDEX_rt__i, branch_taken__i, jump__i, muldiv_start__i, mem_wait__i,
    input  pc_enable__o, ifid_enable__o, ifid_flush__o, idex_bubble__o,
           freeze__o, muldiv_busy__o, stall_cycles__o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO interlocks, branch/jump
// flush, memory-wait freeze, and a saturating stall-cycle counter.
// Control outputs are purely combinational from inputs and registered state.
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic          clock__i,
  input  logic          reset_n__i,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [5:0] CNT_LOAD = 6'(MULDIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;

  logic load_use, hilo_stall, redirect;
  logic pc_en, ifid_en, flush, bubble, frz;

  // Hazard detection; a load into $zero never creates a dependency.
  always_comb begin
    load_use   = hz.IDEX_mem_read__i && (hz.IDEX_rt__i != 5'd0) &&
                 ((hz.IDEX_rt__i == hz.IFID_rs__i) || (hz.IDEX_rt__i == hz.IFID_rt__i));
    hilo_stall = (state_q == BUSY) && hz.IFID_uses_hilo__i;
    redirect   = hz.branch_taken__i || hz.jump__i;
  end

  // Prioritised control outputs: reset, mem_wait, interlock, redirect, none.
  always_comb begin
    pc_en   = 1'b1;
    ifid_en = 1'b1;
    flush   = 1'b0;
    bubble  = 1'b0;
    frz     = 1'b0;
    if (!reset_n__i) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      flush   = 1'b1;
      bubble  = 1'b1;
    end else if (hz.mem_wait__i) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      frz     = 1'b1;
    end else if (load_use || hilo_stall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      bubble  = 1'b1;
    end else if (redirect) begin
      flush   = 1'b1;
    end
  end

  // Mult/div occupancy tracking; a new op always supersedes the pending one,
  // and a frozen pipeline holds everything including the start request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!hz.mem_wait__i) begin
      if (hz.muldiv_start__i) begin
        state_d = BUSY;
        cnt_d   = CNT_LOAD;
      end else if (state_q == BUSY) begin
        if (cnt_q == 6'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
    end
  end

  // Stall-cycle counter sticks at all-ones instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    if (!pc_en && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State, counter and statistics registers.
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign hz.pc_enable__o    = pc_en;
  assign hz.ifid_enable__o  = ifid_en;
  assign hz.ifid_flush__o   = flush;
  assign hz.idex_bubble__o  = bubble;
  assign hz.freeze__o       = frz;
  assign hz.muldiv_busy__o  = (state_q == BUSY);
  assign hz.stall_cycles__o = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a behavioural model predicts every cycle's outputs,
// predictions are queued when stimulus is applied and compared at the
// following falling edge.
module tb_hazard_ctrl;

  localparam int MC = 4;

  logic clk;
  logic rst_n;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MULDIV_CYCLES(MC)) dut (
    .clock__i   (clk),
    .reset_n__i (rst_n),
    .hz         (hif.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pc_en;
    logic        ifid_en;
    logic        flush;
    logic        bubble;
    logic        frz;
    logic        busy;
    logic [15:0] stalls;
  } exp_t;

  exp_t sb_q[$];

  int n_chk;
  int n_pass;

  // Model state: busy flag and number of busy cycles still to come.
  bit m_busy;
  int m_left;
  int m_stalls;

  logic o_busy, o_pc, o_flush;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic lu, hs;
    e = '0;
    if (!rst_n) begin
      e.flush  = 1'b1;
      e.bubble = 1'b1;
      return e;
    end
    lu = hif.IDEX_mem_read__i && (hif.IDEX_rt__i != 5'd0) &&
         (hif.IDEX_rt__i == hif.IFID_rs__i || hif.IDEX_rt__i == hif.IFID_rt__i);
    hs = m_busy && hif.IFID_uses_hilo__i;
    e.busy   = m_busy;
    e.stalls = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    if (hif.mem_wait__i) begin
      e.frz = 1'b1;
    end else if (lu || hs) begin
      e.bubble = 1'b1;
    end else begin
      e.pc_en   = 1'b1;
      e.ifid_en = 1'b1;
      e.flush   = hif.branch_taken__i | hif.jump__i;
    end
    return e;
  endfunction

  task automatic model_update(input exp_t e);
    if (!rst_n) begin
      m_busy = 0; m_left = 0; m_stalls = 0;
    end else begin
      if (!hif.mem_wait__i) begin
        if (hif.muldiv_start__i) begin
          m_busy = 1;
          m_left = MC;
        end else if (m_busy) begin
          m_left--;
          if (m_left == 0) m_busy = 0;
        end
      end
      if (!e.pc_en && m_stalls < 100000) m_stalls++;
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic hilo,
                       input logic mr, input logic [4:0] idrt, input logic br,
                       input logic jp, input logic st, input logic mw);
    hif.IFID_rs__i        = rs;
    hif.IFID_rt__i        = rt;
    hif.IFID_uses_hilo__i = hilo;
    hif.IDEX_mem_read__i  = mr;
    hif.IDEX_rt__i        = idrt;
    hif.branch_taken__i   = br;
    hif.jump__i           = jp;
    hif.muldiv_start__i   = st;
    hif.mem_wait__i       = mw;
  endtask

  // One clock cycle: predict, sample at the falling edge, advance the model.
  task automatic step(input string tag);
    exp_t e, g;
    e = model_out();
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    check_val({tag, ".pc"},     32'(hif.pc_enable__o),    32'(g.pc_en));
    check_val({tag, ".ifid"},   32'(hif.ifid_enable__o),  32'(g.ifid_en));
    check_val({tag, ".flush"},  32'(hif.ifid_flush__o),   32'(g.flush));
    check_val({tag, ".bubble"}, 32'(hif.idex_bubble__o),  32'(g.bubble));
    check_val({tag, ".freeze"}, 32'(hif.freeze__o),       32'(g.frz));
    check_val({tag, ".busy"},   32'(hif.muldiv_busy__o),  32'(g.busy));
    check_val({tag, ".stalls"}, 32'(hif.stall_cycles__o), 32'(g.stalls));
    o_busy  = hif.muldiv_busy__o;
    o_pc    = hif.pc_enable__o;
    o_flush = hif.ifid_flush__o;
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  initial begin
    int busy_cnt, stall_cnt, flush_cnt;
    clk = 1'b0;
    rst_n = 1'b0;
    n_chk = 0; n_pass = 0;
    m_busy = 0; m_left = 0; m_stalls = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset values, including a branch request that must not matter.
    step("rst0");
    drive(0, 0, 1, 0, 0, 1, 0, 1, 0);
    step("rst1");
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle0");
    step("idle1");

    // Load-use on rs, then clear.
    drive(5, 1, 0, 1, 5, 0, 0, 0, 0);
    step("lu_rs");
    check_val("lu_rs.pc_direct", 32'(o_pc), 32'd0);
    drive(5, 1, 0, 0, 5, 0, 0, 0, 0);
    step("lu_after");
    check_val("lu_after.count", 32'(hif.stall_cycles__o), 32'd1);

    // Load into $zero never stalls; load-use on rt does.
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("lu_zero");
    check_val("lu_zero.pc_direct", 32'(o_pc), 32'd1);
    drive(3, 7, 0, 1, 7, 0, 0, 0, 0);
    step("lu_rt");

    // Branch together with load-use: stall wins, then branch alone flushes.
    drive(9, 2, 0, 1, 9, 1, 0, 0, 0);
    step("br_lu");
    check_val("br_lu.flush_direct", 32'(o_flush), 32'd0);
    drive(9, 2, 0, 0, 9, 1, 0, 0, 0);
    step("br_only");
    check_val("br_only.flush_direct", 32'(o_flush), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("jump");

    // Mult/div: busy for exactly MC cycles, HI/LO reader stalls meanwhile.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("md_start");
    busy_cnt = 0; stall_cnt = 0;
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MC + 2; i++) begin
      step("md_hilo");
      if (o_busy) busy_cnt++;
      if (!o_pc) stall_cnt++;
    end
    check_val("md.busy_cycles", 32'(busy_cnt), 32'(MC));
    check_val("md.stall_cycles", 32'(stall_cnt), 32'(MC));

    // mem_wait during BUSY extends it by the wait length, no flush.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mw_start");
    busy_cnt = 0; flush_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mw_pre");
    if (o_busy) busy_cnt++;
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("mw_wait");
      if (o_busy) busy_cnt++;
      if (o_flush) flush_cnt++;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step("mw_post");
      if (o_busy) busy_cnt++;
    end
    check_val("mw.busy_cycles", 32'(busy_cnt), 32'(MC + 3));
    check_val("mw.flushes", 32'(flush_cnt), 32'd0);

    // Start request during mem_wait is ignored; restart in BUSY supersedes.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mw_ign_start");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mw_ign_chk");
    check_val("mw_ign.busy_direct", 32'(o_busy), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rs_start");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rs_mid0");
    step("rs_mid1");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rs_restart");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MC + 1; i++) step("rs_drain");

    // Randomised mix checked against the model.
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 7) == 0));
      step("rand");
    end

    // Saturation of the stall counter under a persistent load-use.
    drive(4, 0, 0, 1, 4, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step("sat");
    check_val("sat.count", 32'(hif.stall_cycles__o), 32'h0000FFFF);

    // Asynchronous reset in the middle of a mult/div.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("ar_start");
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("ar_busy");
    #2;
    rst_n = 1'b0;
    m_busy = 0; m_left = 0; m_stalls = 0;
    #1;
    check_val("ar.busy_now", 32'(hif.muldiv_busy__o), 32'd0);
    check_val("ar.count_now", 32'(hif.stall_cycles__o), 32'd0);
    check_val("ar.flush_now", 32'(hif.ifid_flush__o), 32'd1);
    check_val("ar.pc_now", 32'(hif.pc_enable__o), 32'd0);
    @(posedge clk); #1;
    step("ar_hold");
    rst_n = 1'b1;
    step("ar_release");
    check_val("ar_release.pc_direct", 32'(o_pc), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MULDIV_CYCLES, default 32, cycles a multiply/divide occupies HI/LO (legal range 2..63).
REQ-002 clock__i  in  1  single clock; all state updates on posedge.
REQ-003 reset_n__i  in  1  asynchronous, active-low reset.
REQ-004 IFID_rs__i, IFID_rt__i  in  5 each  source register numbers of the instruction in ID.
REQ-005 IFID_uses_hilo__i  in  1  instruction in ID reads HI/LO (MFHI/MFLO) or starts a mult/div.
REQ-006 IDEX_mem_read__i  in  1  instruction in EX is a load.
REQ-007 IDEX_rt__i  in  5  load destination register in EX.
REQ-008 branch_taken__i  in  1  branch resolved taken in ID.
REQ-009 jump__i  in  1  jump decoded in ID.
REQ-010 muldiv_start__i  in  1  mult/div issued from EX this cycle.
REQ-011 mem_wait__i  in  1  data memory busy; whole pipeline must freeze.
REQ-012 pc_enable__o  out  1  1 = PC loads next value, 0 = hold.
REQ-013 ifid_enable__o  out  1  IF/ID advance control: 1 = relay inputs, 0 = hold (stall).
REQ-014 ifid_flush__o  out  1  1 = clear IF/ID to zero at next edge.
REQ-015 idex_bubble__o  out  1  1 = zero ID/EX control fields (insert NOP).
REQ-016 freeze__o  out  1  1 = hold EX/MEM and MEM/WB.
REQ-017 muldiv_busy__o  out  1  HI/LO result pending.
REQ-018 stall_cycles__o  out  16  saturating count of cycles with pc_enable__o = 0.

Function
REQ-019 States: RUN, BUSY (mult/div pending), encoded in a state register plus a 6-bit down-counter cnt.
REQ-020 load_use = IDEX_mem_read__i & (IDEX_rt__i != 0) & (IDEX_rt__i == IFID_rs__i | IDEX_rt__i == IFID_rt__i).
REQ-021 hilo_stall = (state == BUSY) & IFID_uses_hilo__i.
REQ-022 Priority, highest first: mem_wait, load_use, hilo_stall, redirect (branch_taken | jump), none.
REQ-023 mem_wait: pc_enable=0, ifid_enable=0, freeze=1, idex_bubble=0, ifid_flush=0; state and cnt hold; muldiv_start ignored.
REQ-024 load_use or hilo_stall (no mem_wait): pc_enable=0, ifid_enable=0, idex_bubble=1, ifid_flush=0, freeze=0.
REQ-025 redirect with no stall: ifid_flush=1, pc_enable=1, ifid_enable=1, idex_bubble=0; flush suppressed whenever any stall of REQ-023/024 is active.
REQ-026 No condition: pc_enable=1, ifid_enable=1, all others 0.
REQ-027 Control outputs are combinational from inputs and registered state; zero-cycle latency.
REQ-028 RUN -> BUSY when muldiv_start__i=1 and mem_wait__i=0; cnt loads MULDIV_CYCLES-1.
REQ-029 BUSY: cnt decrements each non-frozen cycle; BUSY -> RUN on the edge where cnt==0.
REQ-030 muldiv_start__i in BUSY restarts cnt at MULDIV_CYCLES-1 (new op supersedes old); takes precedence over cnt==0 exit.
REQ-031 muldiv_busy__o = (state == BUSY).
REQ-032 stall_cycles__o increments when pc_enable__o=0 and reset deasserted; saturates at 16'hFFFF, no wrap.

Reset
REQ-033 reset_n__i low asynchronously forces state=RUN, cnt=0, stall_cycles__o=0.
REQ-034 While reset_n__i low: pc_enable=0, ifid_enable=0, ifid_flush=1, idex_bubble=1, freeze=0, muldiv_busy=0.
REQ-035 Reset asserted mid-BUSY abandons the operation; first cycle after release is RUN with no stall.

Verification
REQ-036 Load-use: IDEX_mem_read=1, IDEX_rt=5, IFID_rs=5 for one cycle -> pc_enable=0, ifid_enable=0, idex_bubble=1; next cycle (mem_read=0) all normal; stall_cycles=1.
REQ-037 $zero load: IDEX_mem_read=1, IDEX_rt=0, IFID_rt=0 -> no stall.
REQ-038 Branch vs load-use same cycle: branch_taken=1 with load_use -> ifid_flush=0, stall asserted; next cycle branch_taken=1 alone -> ifid_flush=1.
REQ-039 Mult/div: MULDIV_CYCLES=4, muldiv_start pulse -> muldiv_busy high exactly 4 cycles; IFID_uses_hilo=1 throughout -> 4 stall cycles, then proceed.
REQ-040 mem_wait=1 for 3 cycles during BUSY -> freeze=1, cnt held, BUSY extended by 3 cycles; branch_taken during wait gives no flush.
REQ-041 Saturation/reset: hold load_use 70000 cycles -> stall_cycles=16'hFFFF; pulse reset_n low mid-BUSY -> counter 0, muldiv_busy 0 immediately.
